// File: rtl/tensor_rd_arbiter_if.sv
// Bus bundle between the two tensor-RAM requesters, the tensor RAM read port
// and the read arbiter that shares it.
interface tensor_rd_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              r0_req;
  logic              r0_lock;
  logic [ADDR_W-1:0] r0_addr;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic              r1_req;
  logic              r1_lock;
  logic [ADDR_W-1:0] r1_addr;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_ren;
  logic [DATA_W-1:0] ram_rdata;
  logic              starve_err;

  // Arbiter side.
  modport slave (
    input  r0_req, r0_lock, r0_addr, r1_req, r1_lock, r1_addr, ram_rdata,
    output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata, ram_raddr, ram_ren,
    starve_err
  );

  // Requester / RAM side.
  modport master (
    output r0_req, r0_lock, r0_addr, r1_req, r1_lock, r1_addr, ram_rdata,
    input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata, ram_raddr, ram_ren,
    starve_err
  );
endinterface

// File: rtl/tensor_rd_arbiter.sv
// Two-requester arbiter for the single read port of the 1024 x int8 heatmap
// tensor RAM; r0 (peak scan) may lock the port, r1 (host readout) is watched for starvation.
module tensor_rd_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 64
) (
  input  logic                clk,
  input  logic                reset,
  tensor_rd_arbiter_if.slave  bus,
  output logic [1:0]          state_dbg
);

  // Handshake: a requester raises req with a stable addr and holds both until it
  // sees its registered gnt; every cycle with gnt=1 and req=1 is one beat, and its
  // data returns exactly one cycle later qualified by that requester's rvalid.

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_t;

  own_t              state, state_nx;
  logic              last_q, last_nx;   // 1 = r1 served last
  logic              beat0, beat1, beat;
  logic [ADDR_W-1:0] raddr, raddr_q;
  logic              rv0_q, rv1_q;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_q;

  always_comb begin
    beat0 = (state == OWN0) && bus.r0_req;
    beat1 = (state == OWN1) && bus.r1_req;
    beat  = beat0 || beat1;
    raddr = raddr_q;
    if (beat0) raddr = bus.r0_addr;
    if (beat1) raddr = bus.r1_addr;
  end

  always_comb begin
    state_nx = state;
    last_nx  = last_q;
    if (beat0) last_nx = 1'b0;
    if (beat1) last_nx = 1'b1;
    case (state)
      IDLE: begin
        if (bus.r0_req && bus.r1_req) state_nx = last_q ? OWN0 : OWN1;
        else if (bus.r0_req)          state_nx = OWN0;
        else if (bus.r1_req)          state_nx = OWN1;
      end
      OWN0: begin
        if (bus.r0_req && bus.r0_lock) state_nx = OWN0;
        else if (bus.r1_req)           state_nx = OWN1;
        else if (!bus.r0_req)          state_nx = IDLE;
      end
      OWN1: begin
        if (bus.r1_req && bus.r1_lock) state_nx = OWN1;
        else if (bus.r0_req)           state_nx = OWN0;
        else if (!bus.r1_req)          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last_q  <= 1'b1;
      raddr_q <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      last_q <= last_nx;
      rv0_q  <= beat0;
      rv1_q  <= beat1;
      if (beat) raddr_q <= raddr;
    end
  end

  // The wait counter never influences ownership, so an r0 lock is never broken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      starve_q   <= 1'b0;
    end else if (bus.r1_req && (state != OWN1)) begin
      if (starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + CNT_W'(1);
      if (starve_cnt >= CNT_W'(STARVE_MAX - 1)) starve_q <= 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  assign bus.r0_gnt     = (state == OWN0);
  assign bus.r1_gnt     = (state == OWN1);
  assign bus.ram_ren    = beat;
  assign bus.ram_raddr  = raddr;
  assign bus.r0_rvalid  = rv0_q;
  assign bus.r1_rvalid  = rv1_q;
  assign bus.rdata      = bus.ram_rdata;
  assign bus.starve_err = starve_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_tensor_rd_arbiter.sv
// Bench for tensor_rd_arbiter: directed vector table, multi-cycle burst/reset/starvation
// sequences and randomized traffic, all checked against a rule-level ownership model.
module tb_tensor_rd_arbiter;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 64;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  tensor_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  tensor_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Values applied to the DUT at the next falling edge.
  logic              d_r0_req = 1'b0, d_r0_lock = 1'b0, d_r1_req = 1'b0, d_r1_lock = 1'b0;
  logic [ADDR_W-1:0] d_r0_addr = '0, d_r1_addr = '0;

  // Tensor RAM content and the bench's RAM port register.
  logic [DATA_W-1:0] mem [1024];
  logic              ram_ren_s;
  logic [ADDR_W-1:0] ram_addr_s;

  // ---------------- reference model ----------------
  int                m_own;     // -1 nobody, 0 r0, 1 r1
  int                m_last;    // requester served most recently
  int                m_wait;    // consecutive r1 waiting cycles
  logic              m_err;
  logic [ADDR_W-1:0] m_raddr;
  logic [DATA_W:0]   exp_q[$];  // {requester id, expected data}, one per beat

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own     = -1;
    m_last    = 1;
    m_wait    = 0;
    m_err     = 1'b0;
    m_raddr   = '0;
    ram_ren_s = 1'b0;
    exp_q.delete();
  endtask

  function automatic int next_owner(input int own, input int last,
                                    input logic [1:0] req, input logic [1:0] lock);
    int o;
    if (own < 0) begin
      if (req == 2'b11) return 1 - last;
      if (req[0])       return 0;
      if (req[1])       return 1;
      return -1;
    end
    o = 1 - own;
    if (req[own] && lock[own]) return own;
    if (req[o])                return o;
    if (req[own])              return own;
    return -1;
  endfunction

  task automatic model_check_and_advance();
    logic [1:0]        req, lock;
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W:0]   e;
    logic              beat;
    req     = {bus.r1_req, bus.r0_req};
    lock    = {bus.r1_lock, bus.r0_lock};
    addr[0] = bus.r0_addr;
    addr[1] = bus.r1_addr;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("r0_rvalid", 32'(bus.r0_rvalid), 32'(!e[DATA_W]));
      chk("r1_rvalid", 32'(bus.r1_rvalid), 32'(e[DATA_W]));
      chk("rdata", 32'(bus.rdata), 32'(e[DATA_W-1:0]));
    end else begin
      chk("r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
      chk("r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
    end
    chk("r0_gnt", 32'(bus.r0_gnt), 32'(m_own == 0));
    chk("r1_gnt", 32'(bus.r1_gnt), 32'(m_own == 1));
    beat = (m_own >= 0) && req[m_own];
    if (beat) m_raddr = addr[m_own];
    chk("ram_ren", 32'(bus.ram_ren), 32'(beat));
    chk("ram_raddr", 32'(bus.ram_raddr), 32'(m_raddr));
    chk("starve_err", 32'(bus.starve_err), 32'(m_err));
    if (beat) begin
      exp_q.push_back({(m_own == 1), mem[addr[m_own]]});
      m_last = m_own;
    end
    if (req[1] && (m_own != 1)) begin
      if (m_wait < STARVE_MAX) m_wait++;
      if (m_wait == STARVE_MAX) m_err = 1'b1;
    end else begin
      m_wait = 0;
    end
    m_own = next_owner(m_own, m_last, req, lock);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: drive at the falling edge, sample 1 ns later, before the rising edge.
  task automatic step();
    @(negedge clk);
    bus.r0_req    = d_r0_req;
    bus.r0_lock   = d_r0_lock;
    bus.r0_addr   = d_r0_addr;
    bus.r1_req    = d_r1_req;
    bus.r1_lock   = d_r1_lock;
    bus.r1_addr   = d_r1_addr;
    bus.ram_rdata = ram_ren_s ? mem[ram_addr_s] : DATA_W'($urandom);
    #1;
    model_check_and_advance();
    ram_ren_s  = bus.ram_ren;
    ram_addr_s = bus.ram_raddr;
  endtask

  // Asynchronous reset from the current time, checks the cleared outputs, releases at a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_r0_gnt", 32'(bus.r0_gnt), 32'd0);
    chk("rst_r1_gnt", 32'(bus.r1_gnt), 32'd0);
    chk("rst_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
    chk("rst_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
    chk("rst_ram_ren", 32'(bus.ram_ren), 32'd0);
    chk("rst_ram_raddr", 32'(bus.ram_raddr), 32'd0);
    chk("rst_starve_err", 32'(bus.starve_err), 32'd0);
    {d_r0_req, d_r0_lock, d_r1_req, d_r1_lock} = 4'b0;
    {bus.r0_req, bus.r0_lock, bus.r1_req, bus.r1_lock} = 4'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [ADDR_W-1:0] burst_addr(input int k);
    return (k == 0) ? '0 : ADDR_W'(k - 1);
  endfunction

  // r0 issues n beats (locked or not); r1 lines are left as the caller set them.
  task automatic r0_burst(input int n, input logic lk, output int r1_gnt_seen);
    int beats = 0;
    int guard = 0;
    r1_gnt_seen = 0;
    d_r0_req  = 1'b1;
    d_r0_lock = lk;
    d_r0_addr = burst_addr(0);
    while (beats < n && guard < n + 200) begin
      step();
      guard++;
      if (bus.r1_gnt) r1_gnt_seen++;
      if (bus.r0_gnt) begin
        beats++;
        d_r0_addr = burst_addr(beats);
      end
    end
    chk("burst_beats", 32'(beats), 32'(n));
    d_r0_req  = 1'b0;
    d_r0_lock = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic              rst;
    logic              q0, l0;
    logic [ADDR_W-1:0] a0;
    logic              q1, l1;
    logic [ADDR_W-1:0] a1;
    logic              g0, g1, ren;
    logic [ADDR_W-1:0] raddr;
    logic              rv0, rv1;
    logic [DATA_W-1:0] rd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int seen;
    logic [1:0]        act;
    logic [1:0]        lk;
    logic [ADDR_W-1:0] ad [2];

    for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
    mem[10'h155] = 8'h7F;
    mem[10'h011] = 8'h81;
    mem[10'h3A2] = 8'h05;
    mem[10'h0AA] = 8'hC3;
    mem[10'h200] = 8'h40;
    model_reset();

    // Single r0 read, then unlocked r0/r1 round robin, then r1 -> r0 hand-off.
    //           rst   q0    l0    a0       q1    l1    a1       g0    g1    ren   raddr    rv0   rv1   rd
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 10'h155, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 10'h155, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h155, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 10'h155, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h155, 1'b1, 1'b0, 8'h7F};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h155, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 10'h011, 1'b1, 1'b0, 10'h3A2, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 10'h011, 1'b1, 1'b0, 10'h3A2, 1'b1, 1'b0, 1'b1, 10'h011, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 10'h011, 1'b1, 1'b0, 10'h3A2, 1'b0, 1'b1, 1'b1, 10'h3A2, 1'b1, 1'b0, 8'h81};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 10'h011, 1'b1, 1'b0, 10'h3A2, 1'b1, 1'b0, 1'b1, 10'h011, 1'b0, 1'b1, 8'h05};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 10'h011, 1'b1, 1'b0, 10'h3A2, 1'b0, 1'b1, 1'b1, 10'h3A2, 1'b1, 1'b0, 8'h81};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 10'h011, 1'b0, 1'b0, 10'h3A2, 1'b1, 1'b0, 1'b0, 10'h3A2, 1'b0, 1'b1, 8'h05};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h3A2, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h0AA, 1'b0, 1'b0, 1'b0, 10'h3A2, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h0AA, 1'b0, 1'b1, 1'b1, 10'h0AA, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 10'h200, 1'b0, 1'b0, 10'h0AA, 1'b0, 1'b1, 1'b0, 10'h0AA, 1'b0, 1'b1, 8'hC3};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 10'h200, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h200, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h200, 1'b1, 1'b0, 8'h40};

    #2;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) do_reset();
      d_r0_req  = tbl[i].q0;
      d_r0_lock = tbl[i].l0;
      d_r0_addr = tbl[i].a0;
      d_r1_req  = tbl[i].q1;
      d_r1_lock = tbl[i].l1;
      d_r1_addr = tbl[i].a1;
      step();
      chk($sformatf("v%0d_r0_gnt", i), 32'(bus.r0_gnt), 32'(tbl[i].g0));
      chk($sformatf("v%0d_r1_gnt", i), 32'(bus.r1_gnt), 32'(tbl[i].g1));
      chk($sformatf("v%0d_ram_ren", i), 32'(bus.ram_ren), 32'(tbl[i].ren));
      chk($sformatf("v%0d_ram_raddr", i), 32'(bus.ram_raddr), 32'(tbl[i].raddr));
      chk($sformatf("v%0d_r0_rvalid", i), 32'(bus.r0_rvalid), 32'(tbl[i].rv0));
      chk($sformatf("v%0d_r1_rvalid", i), 32'(bus.r1_rvalid), 32'(tbl[i].rv1));
      if (tbl[i].rv0 || tbl[i].rv1) chk($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].rd));
    end

    // Locked 1026-beat scan while r1 waits: r1 never granted, starvation flagged.
    do_reset();
    d_r1_req  = 1'b1;
    d_r1_addr = 10'h3FF;
    r0_burst(1026, 1'b1, seen);
    chk("burst_r1_gnt_cycles", 32'(seen), 32'd0);
    chk("burst_starve_err", 32'(bus.starve_err), 32'd1);
    step();
    chk("burst_drop_r1_gnt", 32'(bus.r1_gnt), 32'd0);
    step();
    chk("burst_after_r1_gnt", 32'(bus.r1_gnt), 32'd1);
    d_r1_req = 1'b0;
    step();
    step();
    chk("burst_err_sticky", 32'(bus.starve_err), 32'd1);

    // Asynchronous reset in the middle of a locked scan, right after beat 500.
    do_reset();
    d_r1_req  = 1'b1;
    d_r1_addr = 10'h001;
    r0_burst(500, 1'b1, seen);
    chk("mid_pre_starve_err", 32'(bus.starve_err), 32'd1);
    @(posedge clk);
    #3;
    chk("mid_pre_r0_rvalid", 32'(bus.r0_rvalid), 32'd1);
    do_reset();
    d_r0_req  = 1'b1;
    d_r0_addr = 10'h155;
    d_r1_req  = 1'b1;
    d_r1_addr = 10'h011;
    step();
    chk("mid_post_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
    chk("mid_post_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
    step();
    chk("mid_tie_r0_gnt", 32'(bus.r0_gnt), 32'd1);
    chk("mid_tie_r1_gnt", 32'(bus.r1_gnt), 32'd0);
    d_r0_req = 1'b0;
    d_r1_req = 1'b0;
    step();
    step();
    step();

    // r1 waits 63 cycles, is served, then waits 63 more: no starvation.
    do_reset();
    d_r1_req  = 1'b1;
    d_r1_addr = 10'h0AA;
    r0_burst(61, 1'b1, seen);
    step();
    chk("s63_first_wait_err", 32'(bus.starve_err), 32'd0);
    r0_burst(62, 1'b1, seen);
    chk("s63_burst_r1_gnt", 32'(seen), 32'd1);
    step();
    step();
    chk("s63_second_gnt", 32'(bus.r1_gnt), 32'd1);
    d_r1_req = 1'b0;
    step();
    step();
    chk("s63_starve_err", 32'(bus.starve_err), 32'd0);

    // Random traffic: requesters hold req/addr until granted; lock toggles freely.
    do_reset();
    act = 2'b00;
    lk  = 2'b00;
    ad[0] = '0;
    ad[1] = '0;
    for (int c = 0; c < 2500; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!act[r] && $urandom_range(0, 2) == 0) begin
          act[r] = 1'b1;
          ad[r]  = ADDR_W'($urandom);
          lk[r]  = ($urandom_range(0, 3) == 0);
        end
      end
      d_r0_req  = act[0];
      d_r0_addr = ad[0];
      d_r0_lock = act[0] ? lk[0] : 1'($urandom_range(0, 1));
      d_r1_req  = act[1];
      d_r1_addr = ad[1];
      d_r1_lock = act[1] ? lk[1] : 1'($urandom_range(0, 1));
      step();
      if (act[0] && bus.r0_gnt) begin
        if ($urandom_range(0, 1) == 0) act[0] = 1'b0;
        ad[0] = ADDR_W'($urandom);
        lk[0] = ($urandom_range(0, 3) == 0);
      end
      if (act[1] && bus.r1_gnt) begin
        if ($urandom_range(0, 1) == 0) act[1] = 1'b0;
        ad[1] = ADDR_W'($urandom);
        lk[1] = ($urandom_range(0, 3) == 0);
      end
    end
    d_r0_req = 1'b0;
    d_r1_req = 1'b0;
    step();
    step();
    step();

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete, got %0t, expected < 2000000", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
